// File: rtl/viterbi_pkg.sv
// Shared types and address helpers for the Viterbi traceback scheduler.
// The survivor ring is addressed as {bank, offset}.
package viterbi_pkg;

    localparam int TB_DEPTH_DEF = 32;
    localparam int NB_DEF       = 4;

    typedef enum logic [2:0] {
        IDLE,
        TRAIN,
        DECODE,
        FLUSH,
        DONE
    } tb_state_e;

    function automatic int addr_bank(input int addr, input int off_w);
        return addr >> off_w;
    endfunction

    function automatic int addr_off(input int addr, input int off_w);
        return addr & ((1 << off_w) - 1);
    endfunction

    // Bank wraps modulo the ring, so bank+1 past the last bank lands on bank 0.
    function automatic int make_addr(input int bank, input int off, input int off_w, input int bank_w);
        return ((bank & ((1 << bank_w) - 1)) << off_w) | addr_off(off, off_w);
    endfunction

endpackage

// File: rtl/viterbi_sm_ring.sv
// Survivor-memory ring bookkeeping: write pointer, decode base, occupancy,
// pending flush and the ACS stall derived from them.
module viterbi_sm_ring
    import viterbi_pkg::*;
#(
    parameter int  TB_DEPTH = TB_DEPTH_DEF,
    parameter int  NB       = NB_DEF,
    localparam int ADDR_W   = $clog2(NB * TB_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              i_acs_valid,
    input  logic              i_flush,
    input  logic              i_release,
    input  logic              i_flush_done,
    input  logic              i_clr_flush,
    input  logic              i_in_flush,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_wptr,
    output logic [ADDR_W-1:0] o_dec_base,
    output logic [ADDR_W:0]   o_occ,
    output logic              o_flush_pend,
    output logic              o_stall
);

    localparam logic [ADDR_W:0]   OCC_FULL = (ADDR_W + 1)'(NB * TB_DEPTH);
    localparam logic [ADDR_W:0]   OCC_REL  = (ADDR_W + 1)'(TB_DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(TB_DEPTH);

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] dec_base_q, dec_base_d;
    logic [ADDR_W:0]   occ_q, occ_d;
    logic              flush_pend_q, flush_pend_d;

    assign o_stall      = (occ_q == OCC_FULL) | flush_pend_q | i_in_flush;
    assign o_we         = en & i_acs_valid & ~o_stall;
    assign o_wptr       = wptr_q;
    assign o_dec_base   = dec_base_q;
    assign o_occ        = occ_q;
    assign o_flush_pend = flush_pend_q;

    always_comb begin
        wptr_d       = wptr_q;
        dec_base_d   = dec_base_q;
        occ_d        = occ_q;
        flush_pend_d = flush_pend_q;
        if (o_we) begin
            wptr_d = wptr_q + ADDR_W'(1);
        end
        if (i_flush_done) begin
            dec_base_d = wptr_q;
            occ_d      = '0;
        end else begin
            // A write and a bank release in the same cycle both take effect.
            occ_d = occ_q + (ADDR_W + 1)'(o_we) - (i_release ? OCC_REL : '0);
            if (i_release) begin
                dec_base_d = dec_base_q + DEPTH_A;
            end
        end
        if (flush_pend_q) begin
            if (i_clr_flush) begin
                flush_pend_d = 1'b0;
            end
        end else if (en & i_flush) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q       <= '0;
            dec_base_q   <= '0;
            occ_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            dec_base_q   <= dec_base_d;
            occ_q        <= occ_d;
            flush_pend_q <= flush_pend_d;
        end
    end

endmodule

// File: rtl/viterbi_tb_ctrl.sv
// Traceback scheduler: sequences train/decode reads over the survivor ring
// and the known-state flush traceback at end of frame.
module viterbi_tb_ctrl
    import viterbi_pkg::*;
#(
    parameter int  TB_DEPTH = TB_DEPTH_DEF,
    parameter int  NB       = NB_DEF,
    localparam int ADDR_W   = $clog2(NB * TB_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              i_acs_valid,
    input  logic              i_flush,
    output logic              o_stall,
    output logic              o_sm_we,
    output logic [ADDR_W-1:0] o_sm_waddr,
    output logic              o_sm_re,
    output logic [ADDR_W-1:0] o_sm_raddr,
    output logic              o_tb_init,
    output logic              o_tb_known_state,
    output logic              o_dec_valid,
    output logic              o_frame_done
);

    localparam int                OFF_W     = $clog2(TB_DEPTH);
    localparam int                BANK_W    = $clog2(NB);
    localparam logic [ADDR_W-1:0] DEPTH_M1  = ADDR_W'(TB_DEPTH - 1);
    localparam logic [ADDR_W:0]   OCC_TRAIN = (ADDR_W + 1)'(2 * TB_DEPTH);

    tb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] rcnt_q, rcnt_d;
    logic              dec_valid_q, dec_valid_d;
    logic              release_tb, flush_done, clr_flush;
    logic [ADDR_W-1:0] wptr, dec_base, train_addr, dec_addr, last_wr;
    logic [ADDR_W:0]   occ;
    logic              flush_pend;
    int                base_bank;

    viterbi_sm_ring #(.TB_DEPTH(TB_DEPTH), .NB(NB)) u_ring (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .i_acs_valid  (i_acs_valid),
        .i_flush      (i_flush),
        .i_release    (release_tb),
        .i_flush_done (flush_done),
        .i_clr_flush  (clr_flush),
        .i_in_flush   (state_q == FLUSH),
        .o_we         (o_sm_we),
        .o_wptr       (wptr),
        .o_dec_base   (dec_base),
        .o_occ        (occ),
        .o_flush_pend (flush_pend),
        .o_stall      (o_stall)
    );

    assign o_sm_waddr  = wptr;
    assign o_dec_valid = dec_valid_q;
    assign last_wr     = wptr - ADDR_W'(1);

    // rcnt is a bank offset in TRAIN/DECODE and a full ring address in FLUSH.
    assign base_bank  = addr_bank(int'(dec_base), OFF_W);
    assign train_addr = ADDR_W'(make_addr(base_bank + 1, int'(rcnt_q), OFF_W, BANK_W));
    assign dec_addr   = ADDR_W'(make_addr(base_bank, int'(rcnt_q), OFF_W, BANK_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rcnt_q      <= '0;
            dec_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            dec_valid_q <= dec_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        release_tb  = 1'b0;
        flush_done  = 1'b0;
        clr_flush   = 1'b0;
        dec_valid_d = en & ((state_q == DECODE) | (state_q == FLUSH));
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (occ >= OCC_TRAIN) begin
                        state_d = TRAIN;
                        rcnt_d  = DEPTH_M1;
                    end else if (flush_pend) begin
                        if (occ != '0) begin
                            state_d = FLUSH;
                            rcnt_d  = last_wr;
                        end else begin
                            state_d   = DONE;
                            clr_flush = 1'b1;
                        end
                    end
                end
                TRAIN: begin
                    if (rcnt_q == '0) begin
                        state_d = DECODE;
                        rcnt_d  = DEPTH_M1;
                    end else begin
                        rcnt_d = rcnt_q - ADDR_W'(1);
                    end
                end
                DECODE: begin
                    if (rcnt_q == '0) begin
                        state_d    = IDLE;
                        release_tb = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q - ADDR_W'(1);
                    end
                end
                FLUSH: begin
                    if (rcnt_q == dec_base) begin
                        state_d    = DONE;
                        flush_done = 1'b1;
                        clr_flush  = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q - ADDR_W'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        o_sm_re          = 1'b0;
        o_sm_raddr       = '0;
        o_tb_init        = 1'b0;
        o_tb_known_state = 1'b0;
        o_frame_done     = 1'b0;
        case (state_q)
            TRAIN: begin
                o_sm_re    = en;
                o_sm_raddr = train_addr;
                o_tb_init  = en & (rcnt_q == DEPTH_M1);
            end
            DECODE: begin
                o_sm_re    = en;
                o_sm_raddr = dec_addr;
            end
            FLUSH: begin
                o_sm_re          = en;
                o_sm_raddr       = rcnt_q;
                o_tb_init        = en & (rcnt_q == last_wr);
                o_tb_known_state = en & (rcnt_q == last_wr);
            end
            DONE:    o_frame_done = en;
            default: o_sm_re = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_viterbi_tb_ctrl.sv
// Bench for viterbi_tb_ctrl (TB_DEPTH=4, NB=4) against a job-list reference model.
module tb_viterbi_tb_ctrl;

    localparam int D = 4;
    localparam int N = 4;
    localparam int R = D * N;

    logic       clk = 1'b0;
    logic       rst, en, i_acs_valid, i_flush;
    logic       o_stall, o_sm_we, o_sm_re, o_tb_init, o_tb_known_state, o_dec_valid, o_frame_done;
    logic [3:0] o_sm_waddr, o_sm_raddr;

    always #5 clk = ~clk;

    viterbi_tb_ctrl #(.TB_DEPTH(D), .NB(N)) dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .i_acs_valid      (i_acs_valid),
        .i_flush          (i_flush),
        .o_stall          (o_stall),
        .o_sm_we          (o_sm_we),
        .o_sm_waddr       (o_sm_waddr),
        .o_sm_re          (o_sm_re),
        .o_sm_raddr       (o_sm_raddr),
        .o_tb_init        (o_tb_init),
        .o_tb_known_state (o_tb_known_state),
        .o_dec_valid      (o_dec_valid),
        .o_frame_done     (o_frame_done)
    );

    // Reference model: a traceback is a list of pending reads, one popped per enabled cycle.
    typedef struct {
        int addr;
        bit init;
        bit known;
        bit dv;
    } rd_t;

    rd_t rq[$];
    int  m_wptr, m_base, m_occ, m_writes;
    bit  m_fpend, m_done, m_fjob, m_dv;
    bit  x_stall, x_we, x_re, x_init, x_known, x_done, x_dv;
    int  x_waddr, x_raddr;
    bit  cur_e, cur_v, cur_f;
    logic [14:0] obs, exp_v;
    int  n_vec = 0;
    int  n_fail = 0;

    function automatic void model_reset();
        rq.delete();
        m_wptr = 0; m_base = 0; m_occ = 0; m_writes = 0;
        m_fpend = 0; m_done = 0; m_fjob = 0; m_dv = 0;
    endfunction

    function automatic void push_normal();
        int b;
        b = (m_base / D) % N;
        for (int o = D - 1; o >= 0; o--) begin
            rd_t r;
            r.addr = ((b + 1) % N) * D + o; r.init = (o == D - 1); r.known = 0; r.dv = 0;
            rq.push_back(r);
        end
        for (int o = D - 1; o >= 0; o--) begin
            rd_t r;
            r.addr = b * D + o; r.init = 0; r.known = 0; r.dv = 1;
            rq.push_back(r);
        end
    endfunction

    function automatic void push_flush();
        for (int k = 0; k < m_occ; k++) begin
            rd_t r;
            r.addr = (m_wptr - 1 - k + R) % R; r.init = (k == 0); r.known = (k == 0); r.dv = 1;
            rq.push_back(r);
        end
    endfunction

    function automatic void model_eval();
        x_stall = (m_occ == R) || m_fpend || (m_fjob && rq.size() > 0);
        x_we    = cur_e && cur_v && !x_stall;
        x_waddr = m_wptr;
        x_re    = cur_e && rq.size() > 0;
        x_raddr = x_re ? rq[0].addr : 0;
        x_init  = x_re && rq[0].init;
        x_known = x_init && rq[0].known;
        x_dv    = m_dv;
        x_done  = cur_e && m_done;
    endfunction

    function automatic void model_commit();
        bit clr;
        clr = 0;
        if (!cur_e) begin
            m_dv = 0;
            return;
        end
        m_dv = x_re && rq[0].dv;
        if (m_done) begin
            m_done = 0;
        end else if (rq.size() > 0) begin
            void'(rq.pop_front());
            if (rq.size() == 0) begin
                if (m_fjob) begin
                    m_base = m_wptr; m_occ = 0; m_done = 1; clr = 1; m_fjob = 0;
                end else begin
                    m_base = (m_base + D) % R; m_occ -= D;
                end
            end
        end else if (m_occ >= 2 * D) begin
            push_normal();
        end else if (m_fpend) begin
            if (m_occ > 0) begin
                push_flush(); m_fjob = 1;
            end else begin
                m_done = 1; clr = 1;
            end
        end
        if (x_we) begin
            m_wptr = (m_wptr + 1) % R; m_occ++; m_writes++;
        end
        if (m_fpend) begin
            if (clr) m_fpend = 0;
        end else if (cur_f) begin
            m_fpend = 1;
        end
    endfunction

    function automatic bit seq_bad(input int got[$], input int want[$]);
        if (got.size() != want.size()) return 1;
        foreach (got[i]) if (got[i] != want[i]) return 1;
        return 0;
    endfunction

    task automatic drive_cycle(input bit e, input bit v, input bit f);
        en = e; i_acs_valid = v; i_flush = f;
        cur_e = e; cur_v = v; cur_f = f;
        @(negedge clk);
        model_eval();
        obs   = {o_stall, o_sm_we, o_sm_waddr, o_sm_re, (x_re ? o_sm_raddr : 4'd0),
                 o_tb_init, o_tb_known_state, o_dec_valid, o_frame_done};
        exp_v = {x_stall, x_we, 4'(x_waddr), x_re, 4'(x_raddr), x_init, x_known, x_dv, x_done};
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; i_acs_valid = 1'b0; i_flush = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        drive_cycle(1, 0, 0);
        n_vec++;
        if (obs !== 15'd0 || obs !== exp_v) begin
            n_fail++; $display("FAIL reset_idle obs=%h required=%h", obs, exp_v);
        end
        advance();
        for (int c = 0; c < 10; c++) begin
            drive_cycle(1, 1, 0);
            n_vec++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL reset_prefill cyc %0d obs=%h required=%h", c, obs, exp_v); end
            advance();
        end
        drive_cycle(1, 0, 0);
        n_vec++;
        if (obs !== exp_v || !x_re) begin n_fail++; $display("FAIL reset_in_train obs=%h required=%h", obs, exp_v); end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({o_stall, o_sm_we, o_sm_waddr, o_sm_re, o_sm_raddr, o_tb_init, o_tb_known_state,
             o_dec_valid, o_frame_done} !== 15'd0) begin
            n_fail++; $display("FAIL reset_async outputs not all zero while rst high");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drive_cycle(1, 1, 0);
        n_vec++;
        if (obs !== exp_v || o_sm_waddr !== 4'd0 || o_sm_we !== 1'b1) begin
            n_fail++; $display("FAIL reset_first_write waddr=%0d we=%b required waddr=0 we=1", o_sm_waddr, o_sm_we);
        end
        advance();
    endtask

    task automatic test_normal_tb();
        int got[$];
        int n_dv, n_init, init_addr;
        n_dv = 0; n_init = 0; init_addr = -1;
        do_reset();
        for (int c = 0; c < 22; c++) begin
            drive_cycle(1, c < 8, 0);
            n_vec++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL normal_tb cyc %0d obs=%h required=%h", c, obs, exp_v); end
            if (o_sm_re) got.push_back(int'(o_sm_raddr));
            if (o_dec_valid) n_dv++;
            if (o_tb_init) begin n_init++; init_addr = int'(o_sm_raddr); end
            advance();
        end
        n_vec++;
        if (seq_bad(got, '{7, 6, 5, 4, 3, 2, 1, 0}) || n_dv != 4 || n_init != 1 || init_addr != 7) begin
            n_fail++;
            $display("FAIL normal_tb_seq reads=%0d dv=%0d init=%0d@%0d required 8 reads 7..0, dv=4, init=1@7",
                     got.size(), n_dv, n_init, init_addr);
        end
    endtask

    task automatic test_full_ring();
        int n_we, n_st, w0;
        n_we = 0; n_st = 0;
        do_reset();
        w0 = m_writes;
        for (int c = 0; c < 80; c++) begin
            drive_cycle(1, 1, 0);
            n_vec++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL full_ring cyc %0d obs=%h required=%h", c, obs, exp_v); end
            n_we += int'(o_sm_we);
            n_st += int'(o_stall);
            advance();
        end
        n_vec++;
        if (n_we != m_writes - w0 || n_we + n_st != 80 || n_st == 0) begin
            n_fail++; $display("FAIL full_ring_count writes=%0d stalls=%0d required writes=%0d of 80", n_we, n_st, m_writes - w0);
        end
    endtask

    task automatic test_flush_partial();
        int got[$];
        int n_known, n_done, n_dv;
        n_known = 0; n_done = 0; n_dv = 0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            drive_cycle(1, c < 6, c == 6);
            n_vec++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL flush_partial cyc %0d obs=%h required=%h", c, obs, exp_v); end
            if (o_sm_re) got.push_back(int'(o_sm_raddr));
            if (o_tb_init && o_tb_known_state) n_known++;
            n_done += int'(o_frame_done);
            n_dv   += int'(o_dec_valid);
            advance();
        end
        n_vec++;
        if (seq_bad(got, '{5, 4, 3, 2, 1, 0}) || n_known != 1 || n_done != 1 || n_dv != 6 || o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_partial_seq reads=%0d known=%0d done=%0d dv=%0d stall=%b required 6 reads 5..0, 1, 1, 6, 0",
                     got.size(), n_known, n_done, n_dv, o_stall);
        end
    endtask

    task automatic test_empty_flush();
        int done_at, n_done;
        done_at = -1; n_done = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive_cycle(1, 0, c == 0);
            n_vec++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL empty_flush cyc %0d obs=%h required=%h", c, obs, exp_v); end
            if (o_frame_done) begin n_done++; done_at = c; end
            n_vec++;
            if (o_sm_re !== 1'b0) begin n_fail++; $display("FAIL empty_flush_read cyc %0d re=%b required 0", c, o_sm_re); end
            advance();
        end
        n_vec++;
        if (n_done != 1 || done_at != 2) begin
            n_fail++; $display("FAIL empty_flush_done pulses=%0d at=%0d required 1 at 2", n_done, done_at);
        end
    endtask

    task automatic test_freeze();
        int got[$];
        int k;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive_cycle(1, 1, 0);
            n_vec++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL freeze_fill cyc %0d obs=%h required=%h", c, obs, exp_v); end
            advance();
        end
        k = 0;
        while (!(rq.size() > 0 && rq[0].dv && rq[0].addr == 2) && k < 40) begin
            drive_cycle(1, 0, 0);
            n_vec++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL freeze_run cyc %0d obs=%h required=%h", k, obs, exp_v); end
            advance();
            k++;
        end
        n_vec++;
        if (k >= 40) begin n_fail++; $display("FAIL freeze_reach cycles=%0d required <40", k); end
        for (int c = 0; c < 3; c++) begin
            drive_cycle(0, 1, 0);
            n_vec++;
            if (obs !== exp_v || o_sm_raddr !== 4'd2 || o_sm_re !== 1'b0 || o_sm_we !== 1'b0) begin
                n_fail++; $display("FAIL freeze_hold cyc %0d raddr=%0d re=%b we=%b required 2 0 0", c, o_sm_raddr, o_sm_re, o_sm_we);
            end
            advance();
        end
        for (int c = 0; c < 6; c++) begin
            drive_cycle(1, 0, 0);
            n_vec++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL freeze_resume cyc %0d obs=%h required=%h", c, obs, exp_v); end
            if (o_sm_re) got.push_back(int'(o_sm_raddr));
            advance();
        end
        n_vec++;
        if (seq_bad(got, '{2, 1, 0})) begin
            n_fail++; $display("FAIL freeze_seq reads=%0d required 2,1,0", got.size());
        end
    endtask

    task automatic test_back_to_back();
        int got[$];
        int n_done, known_at;
        n_done = 0; known_at = -1;
        do_reset();
        for (int c = 0; c < 34; c++) begin
            drive_cycle(1, c < 8, c == 7);
            n_vec++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL back_to_back cyc %0d obs=%h required=%h", c, obs, exp_v); end
            if (o_sm_re) got.push_back(int'(o_sm_raddr));
            if (o_tb_known_state) known_at = got.size() - 1;
            n_done += int'(o_frame_done);
            advance();
        end
        n_vec++;
        if (seq_bad(got, '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6, 5, 4}) || n_done != 1 || known_at != 8) begin
            n_fail++;
            $display("FAIL back_to_back_seq reads=%0d done=%0d known_idx=%0d required 12 reads, 1, 8",
                     got.size(), n_done, known_at);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
            n_vec++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL random cyc %0d obs=%h required=%h", c, obs, exp_v); end
            advance();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; i_acs_valid = 1'b0; i_flush = 1'b0;
        model_reset();
        #12;
        test_reset();
        test_normal_tb();
        test_full_ring();
        test_flush_partial();
        test_empty_flush();
        test_freeze();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
